// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, pixel width,
// and the framebuffer arbiter state encoding.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int PIX_W = 8;

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      FILL  = 2'd1,
      SCAN  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host write handshake plus framebuffer RAM bus.
// slave = arbiter side, master = host/RAM side.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = vga_pkg::PIX_W
);

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              ram_re;
   logic [PIX_W-1:0]  ram_wdata;
   logic [PIX_W-1:0]  ram_rdata;

   modport slave (
      input  wr_valid, wr_addr, wr_data, ram_rdata,
      output wr_ready, ram_addr, ram_we, ram_re, ram_wdata
   );

   modport master (
      output wr_valid, wr_addr, wr_data, ram_rdata,
      input  wr_ready, ram_addr, ram_we, ram_re, ram_wdata
   );

endinterface

// File: rtl/vga_pix_fifo.sv
// Small synchronous prefetch FIFO with flush and
// first-word-fall-through head.
module vga_pix_fifo #(
   parameter  int DEPTH = 4,
   parameter  int PIX_W = vga_pkg::PIX_W,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [PIX_W-1:0] din,
   input  logic             pop,
   output logic [PIX_W-1:0] dout,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PIX_W-1:0] mem_q [DEPTH];

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wp_q] <= din;
   end

   // Reads are only issued with room reserved, so this never fires.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && cnt_q == CW'(DEPTH)))
            else $error("vga_pix_fifo: push into full FIFO");
      end
   end

   assign dout  = mem_q[rp_q];
   assign count = cnt_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer between VGA scanout
// (prefetched into a FIFO) and a valid/ready host write port.
module vga_fb_arbiter #(
   parameter int H_PIX  = 640,
   parameter int V_PIX  = 480,
   parameter int PIX_W  = vga_pkg::PIX_W,
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             pix_en,
   output logic [PIX_W-1:0] pix_o,
   output logic             underflow_o,
   vga_fb_arbiter_if.slave  bus
);

   import vga_pkg::*;

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int OW  = CW + 1;
   localparam int AW1 = ADDR_W + 1;
   localparam logic [AW1-1:0] TOTAL = AW1'(H_PIX * V_PIX);

   arb_state_e       state_q, state_d;
   logic [AW1-1:0]   rd_addr_q, rd_addr_d;
   logic             inflight_q, inflight_d;
   logic             underflow_q, underflow_d;
   logic [CW-1:0]    count;
   logic [PIX_W-1:0] head;
   logic [OW-1:0]    occ;
   logic             empty, pop, push, active;
   logic             rd_req, wr_go;

   assign empty  = (count == '0);
   assign pop    = pix_en & ~empty;
   assign push   = inflight_q & ~frame_start;
   assign active = (state_q == FILL) || (state_q == SCAN);

   // Occupancy counts the read already in flight so we never overfill.
   assign occ = OW'(count) + OW'(inflight_q) - OW'(pop);

   assign rd_req = active && (rd_addr_q < TOTAL)
                   && (occ < OW'(DEPTH))
                   && !frame_start && !rst;

   assign bus.wr_ready = ~rd_req & ~frame_start & ~rst;
   assign wr_go        = bus.wr_valid & bus.wr_ready;

   always_comb begin
      bus.ram_re    = rd_req;
      bus.ram_we    = wr_go;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (rd_req) begin
         bus.ram_addr = rd_addr_q[ADDR_W-1:0];
      end else if (wr_go) begin
         bus.ram_addr  = bus.wr_addr;
         bus.ram_wdata = bus.wr_data;
      end
   end

   assign pix_o       = (pop && !rst) ? head : '0;
   assign underflow_o = underflow_q;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      underflow_d = underflow_q;
      inflight_d  = rd_req;
      if (frame_start) begin
         state_d     = FILL;
         rd_addr_d   = '0;
         underflow_d = 1'b0;
      end else begin
         if (rd_req) rd_addr_d = rd_addr_q + AW1'(1);
         if (pix_en && empty) underflow_d = 1'b1;
         unique case (state_q)
            FILL: if (pix_en) state_d = SCAN;
            SCAN: begin
               if (rd_addr_q == TOTAL && empty && !inflight_q)
                  state_d = BLANK;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BLANK;
         rd_addr_q   <= '0;
         inflight_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         inflight_q  <= inflight_d;
         underflow_q <= underflow_d;
      end
   end

   vga_pix_fifo #(
      .DEPTH (DEPTH),
      .PIX_W (PIX_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (frame_start),
      .push  (push),
      .din   (bus.ram_rdata),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: 8x2 frame, 4-deep FIFO,
// behavioural RAM preloaded with data = address.
module tb_vga_fb_arbiter;

   localparam int H  = 8;
   localparam int V  = 2;
   localparam int D  = 4;
   localparam int AW = 5;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          pix_en;
   logic          mem_init;
   logic [PW-1:0] pix_o;
   logic          underflow_o;
   logic [PW-1:0] mem [32];
   logic [PW-1:0] exp_pix;

   int vectors    = 0;
   int errors     = 0;
   int collisions = 0;

   vga_fb_arbiter_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

   vga_fb_arbiter #(
      .H_PIX  (H),
      .V_PIX  (V),
      .PIX_W  (PW),
      .ADDR_W (AW),
      .DEPTH  (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_en      (pix_en),
      .pix_o       (pix_o),
      .underflow_o (underflow_o),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
      if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_re && bus.ram_we) collisions <= collisions + 1;
   end

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; mem_init = 1'b1;
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 8'h11;
      #1;
      vectors++;
      if (bus.wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready);
      end
      vectors++;
      if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0) begin
         errors++;
         $display("FAIL rst_ram_en: got we=%b re=%b want 0 0",
                  bus.ram_we, bus.ram_re);
      end
      vectors++;
      if (bus.ram_addr !== 5'd0) begin
         errors++;
         $display("FAIL rst_ram_addr: got %0d want 0", bus.ram_addr);
      end
      @(negedge clk);
      rst = 1'b0; mem_init = 1'b0; bus.wr_valid = 1'b0;
      #1;
      vectors++;
      if (bus.ram_re !== 1'b0 || bus.wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_blank: got re=%b rdy=%b want 0 1",
                  bus.ram_re, bus.wr_ready);
      end
      vectors++;
      if (pix_o !== 8'h00 || underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_out: got pix=%0h uf=%b want 0 0",
                  pix_o, underflow_o);
      end
   endtask

   task automatic test_fill();
      @(negedge clk);
      frame_start = 1'b1;
      #1;
      vectors++;
      if (bus.ram_re !== 1'b0 || bus.wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL fs_cycle: got re=%b rdy=%b want 0 0",
                  bus.ram_re, bus.wr_ready);
      end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         frame_start = 1'b0;
         #1;
         vectors++;
         if (bus.ram_re !== 1'b1 || bus.ram_addr !== 5'(c - 1)
             || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_read c%0d: got re=%b a=%0d rdy=%b want 1 %0d 0",
                     c, bus.ram_re, bus.ram_addr, bus.wr_ready, c - 1);
         end
      end
      for (int c = 5; c <= 7; c++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (bus.ram_re !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_full c%0d: got re=%b rdy=%b want 0 1",
                     c, bus.ram_re, bus.wr_ready);
         end
      end
   endtask

   task automatic test_line_scan();
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         vectors++;
         if (pix_o !== 8'(j)) begin
            errors++;
            $display("FAIL scan_pix j%0d: got %0h want %0h", j, pix_o, j);
         end
         vectors++;
         if (bus.ram_re !== 1'b1 || bus.ram_addr !== 5'(4 + j)) begin
            errors++;
            $display("FAIL scan_read j%0d: got re=%b a=%0d want 1 %0d",
                     j, bus.ram_re, bus.ram_addr, 4 + j);
         end
      end
   endtask

   task automatic test_write_arbitration();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         pix_en = 1'b0;
         bus.wr_valid = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 8'h55;
         #1;
         vectors++;
         if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b0
             || bus.ram_addr !== 5'd16 || bus.ram_wdata !== 8'h55) begin
            errors++;
            $display("FAIL hblank_wr k%0d: got we=%b re=%b a=%0d d=%0h want 1 0 16 55",
                     k, bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata);
         end
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         vectors++;
         if (pix_o !== 8'(8 + j)) begin
            errors++;
            $display("FAIL line2_pix j%0d: got %0h want %0h", j, pix_o, 8 + j);
         end
         vectors++;
         if (j < 4) begin
            if (bus.ram_re !== 1'b1 || bus.ram_addr !== 5'(12 + j)
                || bus.wr_ready !== 1'b0 || bus.ram_we !== 1'b0) begin
               errors++;
               $display("FAIL line2_rd j%0d: got re=%b a=%0d rdy=%b we=%b want 1 %0d 0 0",
                        j, bus.ram_re, bus.ram_addr, bus.wr_ready,
                        bus.ram_we, 12 + j);
            end
         end else begin
            if (bus.ram_re !== 1'b0 || bus.ram_we !== 1'b1
                || bus.ram_addr !== 5'd16) begin
               errors++;
               $display("FAIL line2_wr j%0d: got re=%b we=%b a=%0d want 0 1 16",
                        j, bus.ram_re, bus.ram_we, bus.ram_addr);
            end
         end
      end
      @(negedge clk);
      pix_en = 1'b0; bus.wr_valid = 1'b0;
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'hAA;
      #1;
      vectors++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== 5'd3
          || bus.ram_wdata !== 8'hAA) begin
         errors++;
         $display("FAIL vblank_wr: got we=%b a=%0d d=%0h want 1 3 aa",
                  bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      vectors++;
      if (underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL frame_uf: got %b want 0", underflow_o);
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_write_readback();
      @(negedge clk);
      frame_start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         frame_start = 1'b0;
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         exp_pix = (j == 3) ? 8'hAA : 8'(j);
         vectors++;
         if (pix_o !== exp_pix) begin
            errors++;
            $display("FAIL readback j%0d: got %0h want %0h", j, pix_o, exp_pix);
         end
      end
   endtask

   task automatic test_flush_mid_scan();
      @(negedge clk);
      frame_start = 1'b1; pix_en = 1'b1;
      #1;
      vectors++;
      if (bus.ram_re !== 1'b0 || bus.wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_fs: got re=%b rdy=%b want 0 0",
                  bus.ram_re, bus.wr_ready);
      end
      @(negedge clk);
      frame_start = 1'b0; pix_en = 1'b0;
      #1;
      vectors++;
      if (bus.ram_re !== 1'b1 || bus.ram_addr !== 5'd0) begin
         errors++;
         $display("FAIL flush_restart: got re=%b a=%0d want 1 0",
                  bus.ram_re, bus.ram_addr);
      end
      for (int c = 2; c <= 5; c++) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         vectors++;
         if (pix_o !== 8'(j)) begin
            errors++;
            $display("FAIL flush_pix j%0d: got %0h want %0h", j, pix_o, j);
         end
      end
      @(negedge clk);
      pix_en = 1'b0;
      #1;
      vectors++;
      if (underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_uf: got %b want 0", underflow_o);
      end
   endtask

   task automatic test_underflow();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; pix_en = 1'b1;
      #1;
      vectors++;
      if (pix_o !== 8'h00) begin
         errors++;
         $display("FAIL uf_pix: got %0h want 0", pix_o);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         pix_en = 1'b0;
         #1;
         vectors++;
         if (underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky c%0d: got %b want 1", c, underflow_o);
         end
      end
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      #1;
      vectors++;
      if (underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL uf_clear: got %b want 0", underflow_o);
      end
   endtask

   task automatic test_rst_mid_scan();
      for (int c = 2; c <= 5; c++) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         vectors++;
         if (pix_o !== 8'(j)) begin
            errors++;
            $display("FAIL prerst_pix j%0d: got %0h want %0h", j, pix_o, j);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 8'h77;
      #1;
      vectors++;
      if (bus.wr_ready !== 1'b0 || bus.ram_re !== 1'b0
          || bus.ram_we !== 1'b0 || pix_o !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: got rdy=%b re=%b we=%b pix=%0h want 0 0 0 0",
                  bus.wr_ready, bus.ram_re, bus.ram_we, pix_o);
      end
      @(negedge clk);
      rst = 1'b0; pix_en = 1'b0; bus.wr_valid = 1'b0;
      #1;
      vectors++;
      if (bus.ram_re !== 1'b0 || bus.ram_addr !== 5'd0
          || pix_o !== 8'h00 || underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL post_rst: got re=%b a=%0d pix=%0h uf=%b want 0 0 0 0",
                  bus.ram_re, bus.ram_addr, pix_o, underflow_o);
      end
      @(negedge clk);
      frame_start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         frame_start = 1'b0;
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         pix_en = 1'b1;
         #1;
         exp_pix = (j == 3) ? 8'hAA : 8'(j);
         vectors++;
         if (pix_o !== exp_pix) begin
            errors++;
            $display("FAIL rst_rescan j%0d: got %0h want %0h", j, pix_o, exp_pix);
         end
      end
      @(negedge clk);
      pix_en = 1'b0;
      #1;
      vectors++;
      if (underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_rescan_uf: got %b want 0", underflow_o);
      end
   endtask

   task automatic test_no_collision();
      vectors++;
      if (collisions !== 0) begin
         errors++;
         $display("FAIL re_we_overlap: got %0d cycles want 0", collisions);
      end
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b1;
      frame_start = 1'b0; pix_en = 1'b0;
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      test_reset();
      test_fill();
      test_line_scan();
      test_write_arbitration();
      test_write_readback();
      test_flush_mid_scan();
      test_underflow();
      test_rst_mid_scan();
      test_no_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two users:
  - VGA scanout, which must never starve;
  - a host write port using valid/ready.
- Sits between the VGA timing generator and the framebuffer RAM.
- Prefetches pixels into a small FIFO ahead of active video, and pops one pixel per active-video cycle.
- Host writes get every RAM cycle that scanout does not need.

Parameters:
- H_PIX, 640, active pixels per line.
- V_PIX, 480, active lines per frame.
- PIX_W, 8, pixel data width.
- ADDR_W, 19, RAM address width. Must satisfy 2^ADDR_W >= H_PIX*V_PIX.
- DEPTH, 4, prefetch FIFO depth. Power of two, >= 2.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse during vertical sync (start of frame).
- pix_en  in  1  active-video strobe (h-valid AND v-valid): pop one pixel this cycle.
- pix_o  out  PIX_W  pixel for the current pix_en cycle (combinational from FIFO head).
- underflow_o  out  1  sticky flag: pix_en arrived with FIFO empty.
- wr_valid  in  1  host write request.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  PIX_W  host write data.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_wdata  out  PIX_W  RAM write data.
- ram_rdata  in  PIX_W  RAM read data, valid exactly 1 cycle after ram_re.

Behaviour:
- Reset values:
  - state=BLANK; rd_addr=0; FIFO empty; inflight=0.
  - underflow_o=0; wr_ready=0; ram_we=0; ram_re=0; ram_addr=0; ram_wdata=0; pix_o=0.
- FSM states:
  - BLANK: no scanout reads. Host owns RAM.
  - FILL: prefetch before first active pixel of the frame.
  - SCAN: active frame, reads interleaved with pops.
- FSM transitions:
  - Any state, on frame_start: flush FIFO, drop any in-flight read, rd_addr=0, clear underflow_o, go FILL. frame_start wins over every other event in the same cycle.
  - FILL -> SCAN on the first pix_en.
  - SCAN -> BLANK once the read for address H_PIX*V_PIX-1 has been issued and the FIFO is empty.
- Occupancy and read issue:
  - occ = fifo_count + inflight - (pix_en & fifo_count!=0).
  - rd_req = (state is FILL or SCAN) & rd_addr < H_PIX*V_PIX & occ < DEPTH.
  - Ties (same cycle): frame_start > rd_req > host write. wr_ready = ~rd_req & ~frame_start & ~rst.
- RAM drive:
  - rd_req: ram_re=1, ram_addr=rd_addr, rd_addr++. Next cycle, ram_rdata is pushed into the FIFO (inflight=1).
  - Host write accepted: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, same cycle (combinational grant). ram_re and ram_we are never both 1.
- Steady state in SCAN: one read per pix_en cycle. Host gets horizontal and vertical blanking cycles, plus any cycle with a full FIFO.
- Pop and push in the same cycle is legal; count is unchanged.
- A push into a full FIFO cannot happen by construction. Assert this in simulation.
- pix_en with FIFO empty:
  - pix_o=0, underflow_o set (sticky until next frame_start or rst);
  - rd_addr is not advanced. Pixels shift, and the frame recovers on the next frame_start.
- pix_en in BLANK: pix_o=0, underflow_o set.
- Reset mid-frame: all state returns to reset values. The in-flight read's data is discarded.
- Latency:
  - frame_start to first ram_re: 1 cycle.
  - FIFO full (DEPTH entries) DEPTH+1 cycles after frame_start, assuming no pix_en.
  - Timing generator requirement: at least DEPTH+1 cycles between frame_start and the first pix_en. Guaranteed by the back porch.
- Widths:
  - fifo_count is $clog2(DEPTH)+1 bits.
  - The rd_addr compare uses ADDR_W+1 bits to avoid wrap at the maximum address.

Decomposition:
- Shared package vga_pkg holds:
  - VGA timing constants (H/V pixels, sync pulse, porches, totals);
  - PIX_W;
  - arbiter state encoding (BLANK/FILL/SCAN).
- One sub-module: vga_pix_fifo. Synchronous FIFO, DEPTH x PIX_W, push/pop/flush, count output, first-word-fall-through head.

Test Plan:
- Use H_PIX=8, V_PIX=2, DEPTH=4, and RAM preloaded with data=addr. In every test, ram_re & ram_we is never 1.
- Reset then frame_start, no pix_en:
  - ram_re high for 4 cycles, addr 0..3;
  - FIFO count reaches 4 at cycle 5;
  - wr_ready high from cycle 5.
- After fill, pix_en held 8 cycles:
  - pix_o = 0,1,...,7 with no bubbles;
  - ram_addr reads 4..11, one per cycle.
- wr_valid held high during a line:
  - no write is granted while a read is needed;
  - writes are granted in blanking.
  - Write addr 3, data 0xAA accepted in BLANK -> next frame pixel 3 = 0xAA.
- pix_en asserted 1 cycle after frame_start:
  - pix_o=0, underflow_o=1 and stays 1;
  - next frame_start clears it.
- frame_start asserted mid-SCAN at pixel 5, with a read in flight:
  - FIFO flushed; in-flight data dropped;
  - the next pops return 0,1,2.
- rst pulsed mid-SCAN:
  - all outputs return to reset values the next cycle;
  - the next frame scans from address 0 correctly.
